// File: rtl/alu_pkg.sv
// Shared opcode and flag types for the pipelined ALU.
package alu_pkg;
  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'b000,
    ALU_LSL      = 3'b001,
    ALU_ADD      = 3'b010,
    ALU_SUBTRACT = 3'b011,
    ALU_AND      = 3'b100,
    ALU_OR       = 3'b101,
    ALU_XOR      = 3'b110,
    ALU_LSR      = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic n;
    logic z;
    logic v;
    logic c;
  } alu_flags_t;
endpackage

// File: rtl/alu_core.sv
// Combinational ALU: result and NZVC for one operation.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_e          op,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags
);
  localparam int SH_W = $clog2(WIDTH);

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SH_W-1:0]  shamt;

  // ADD and SUB share one adder; SUB is A + ~B + 1, so C=1 means no borrow.
  assign sub   = (op == ALU_SUBTRACT);
  assign b_eff = sub ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
  assign shamt = b[SH_W-1:0];

  always_comb begin
    result = '0;
    flags  = '0;
    case (op)
      ALU_LSL: result = a << shamt;
      ALU_LSR: result = a >> shamt;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_ADD, ALU_SUBTRACT: begin
        result  = sum[WIDTH-1:0];
        flags.c = sum[WIDTH];
        flags.v = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = b;
    endcase
    flags.n = result[WIDTH-1];
    flags.z = (result == '0);
  end
endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU with valid/ready on both sides, pass-through tag and a
// committed NZVC register updated when a flag-setting op retires.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_cntrl,
  input  logic             in_set_flags,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_negative,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_carry,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags_nzvc
);
  logic [2:1]       vld_pipe;
  logic             s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b;
  alu_op_e          s1_op;
  logic             s1_set;
  logic [TAG_W-1:0] s1_tag;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic [WIDTH-1:0] s2_result;
  alu_flags_t       s2_flags;
  logic             s2_set;
  logic [TAG_W-1:0] s2_tag;

  assign s2_adv   = !vld_pipe[2] || out_ready;
  assign s1_adv   = !vld_pipe[1] || s2_adv;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (s2_adv) vld_pipe[2] <= vld_pipe[1];
      if (s1_adv) vld_pipe[1] <= in_valid;
    end
  end

  // Operand stage only loads on a real accept; its contents never reach outputs directly.
  always_ff @(posedge clk) begin
    if (in_valid && s1_adv && !flush) begin
      s1_a   <= in_a;
      s1_b   <= in_b;
      s1_op  <= alu_op_e'(in_cntrl);
      s1_set <= in_set_flags;
      s1_tag <= in_tag;
    end
  end

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .result (core_result),
    .flags  (core_flags)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_result <= '0;
      s2_flags  <= '0;
      s2_set    <= 1'b0;
      s2_tag    <= '0;
    end else if (s2_adv && vld_pipe[1]) begin
      s2_result <= core_result;
      s2_flags  <= core_flags;
      s2_set    <= s1_set;
      s2_tag    <= s1_tag;
    end
  end

  // Retirement is independent of flush: an op leaving this cycle still commits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                flags_nzvc <= 4'b0000;
    else if (vld_pipe[2] && out_ready && s2_set) flags_nzvc <= s2_flags;
  end

  assign out_valid    = vld_pipe[2];
  assign out_result   = s2_result;
  assign out_tag      = s2_tag;
  assign out_negative = s2_flags.n;
  assign out_zero     = s2_flags.z;
  assign out_overflow = s2_flags.v;
  assign out_carry    = s2_flags.c;
endmodule
